// File: rtl/off_mem_txn_arbiter_if.sv
// Bundle of requester-side and master-side signals shared by the off-memory arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters' and AXI master's view.
interface off_mem_txn_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MODE_WIDTH = 2
);
  // Handshake: rN_req is a level that is held, with its fields stable, until the
  // cycle rN_done pulses. rN_done acts as a one-cycle valid for rN_rdata and rN_err.
  // m_init_txn is a one-cycle start; m_txn_done is a level whose rising edge marks completion.
  logic                  r0_req;
  logic                  r0_wr;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_gnt;
  logic                  r0_done;
  logic [DATA_WIDTH-1:0] r0_rdata;
  logic                  r0_err;

  logic                  r1_req;
  logic                  r1_wr;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_gnt;
  logic                  r1_done;
  logic [DATA_WIDTH-1:0] r1_rdata;
  logic                  r1_err;

  logic [MODE_WIDTH-1:0] m_mode;
  logic [ADDR_WIDTH-1:0] m_addra;
  logic [ADDR_WIDTH-1:0] m_addrb;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_init_txn;
  logic                  m_txn_done;
  logic                  m_error;

  modport master (
    input  r0_req, r0_wr, r0_addr, r0_wdata,
    input  r1_req, r1_wr, r1_addr, r1_wdata,
    input  m_rdata, m_txn_done, m_error,
    output r0_gnt, r0_done, r0_rdata, r0_err,
    output r1_gnt, r1_done, r1_rdata, r1_err,
    output m_mode, m_addra, m_addrb, m_wdata, m_init_txn
  );

  modport slave (
    output r0_req, r0_wr, r0_addr, r0_wdata,
    output r1_req, r1_wr, r1_addr, r1_wdata,
    output m_rdata, m_txn_done, m_error,
    input  r0_gnt, r0_done, r0_rdata, r0_err,
    input  r1_gnt, r1_done, r1_rdata, r1_err,
    input  m_mode, m_addra, m_addrb, m_wdata, m_init_txn
  );
endinterface

// File: rtl/off_mem_txn_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite user-side master between a load path (r0)
// and a store path (r1), one transaction in flight, with a WAIT-state watchdog.
module off_mem_txn_arbiter #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MODE_WIDTH     = 2,
  parameter logic [MODE_WIDTH-1:0] MODE_READ      = 2'b01,
  parameter logic [MODE_WIDTH-1:0] MODE_WRITE     = 2'b10,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  off_mem_txn_arbiter_if.master bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state;
  logic                  r_rr;
  logic                  r_id;
  logic                  r_wr;
  logic                  r_txn_prev;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_gnt;
  logic [1:0]            r_done;
  logic [1:0]            r_err;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic [MODE_WIDTH-1:0] r_mode;
  logic [ADDR_WIDTH-1:0] r_addra;
  logic [ADDR_WIDTH-1:0] r_addrb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_init;

  logic                  w_any;
  logic                  w_pick;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_edge;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_cap_rdata;

  // With both pending, r_rr names the favoured requester; otherwise the lone requester wins.
  assign w_any       = bus.r0_req | bus.r1_req;
  assign w_pick      = (bus.r0_req & bus.r1_req) ? r_rr : bus.r1_req;
  assign w_sel_wr    = w_pick ? bus.r1_wr    : bus.r0_wr;
  assign w_sel_addr  = w_pick ? bus.r1_addr  : bus.r0_addr;
  assign w_sel_wdata = w_pick ? bus.r1_wdata : bus.r0_wdata;

  // Only a fresh rising edge completes, so a level left high by the master is harmless.
  assign w_edge      = bus.m_txn_done & ~r_txn_prev;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_cap_rdata = r_wr ? '0 : bus.m_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr       <= 1'b0;
      r_id       <= 1'b0;
      r_wr       <= 1'b0;
      r_txn_prev <= 1'b0;
      r_cnt      <= '0;
      r_gnt      <= 2'b00;
      r_done     <= 2'b00;
      r_err      <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_mode     <= '0;
      r_addra    <= '0;
      r_addrb    <= '0;
      r_wdata    <= '0;
      r_init     <= 1'b0;
    end else begin
      r_txn_prev <= bus.m_txn_done;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_pick;
            r_wr    <= w_sel_wr;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_init  <= 1'b1;
            r_mode  <= w_sel_wr ? MODE_WRITE : MODE_READ;
            r_addra <= w_sel_wr ? '0 : w_sel_addr;
            r_addrb <= w_sel_wr ? w_sel_addr : '0;
            r_wdata <= w_sel_wr ? w_sel_wdata : '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_init  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_edge) begin
            r_done     <= r_id ? 2'b10 : 2'b01;
            r_err[r_id] <= bus.m_error;
            if (r_id) r_rdata1 <= w_cap_rdata;
            else      r_rdata0 <= w_cap_rdata;
            r_state    <= S_DONE;
          end else if (w_timeout) begin
            r_done      <= r_id ? 2'b10 : 2'b01;
            r_err[r_id] <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_done   <= 2'b00;
          r_err    <= 2'b00;
          r_rdata0 <= '0;
          r_rdata1 <= '0;
          r_gnt    <= 2'b00;
          r_mode   <= '0;
          r_addra  <= '0;
          r_addrb  <= '0;
          r_wdata  <= '0;
          r_rr     <= ~r_id;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.r0_gnt     = r_gnt[0];
  assign bus.r0_done    = r_done[0];
  assign bus.r0_rdata   = r_rdata0;
  assign bus.r0_err     = r_err[0];
  assign bus.r1_gnt     = r_gnt[1];
  assign bus.r1_done    = r_done[1];
  assign bus.r1_rdata   = r_rdata1;
  assign bus.r1_err     = r_err[1];
  assign bus.m_mode     = r_mode;
  assign bus.m_addra    = r_addra;
  assign bus.m_addrb    = r_addrb;
  assign bus.m_wdata    = r_wdata;
  assign bus.m_init_txn = r_init;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_off_mem_txn_arbiter.sv
// Scoreboard bench for off_mem_txn_arbiter: directed transactions against a small slave model,
// with a monitor that pops expected master-side issues and requester responses.
module tb_off_mem_txn_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  off_mem_txn_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MODE_WIDTH(MW)) bus ();

  off_mem_txn_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MODE_WIDTH(MW),
    .MODE_READ(2'b01), .MODE_WRITE(2'b10), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;
  int n_done = 0;
  int n_init = 0;
  int n_dual_gnt = 0;
  int n_dual_done = 0;
  int n_long_init = 0;
  int last_init_cyc = 0;
  int last_done_cyc = -1;
  int slave_rise_cyc = 0;
  bit chk_turn = 1'b0;
  logic prev_init = 1'b0;

  logic [49:0] exp_iss_q[$];
  logic [33:0] exp_rsp_q[$];

  logic slave_hang = 1'b0;
  logic slave_err = 1'b0;
  logic slave_done = 1'b0;
  logic man_done = 1'b0;
  int   slave_lat = 3;
  logic [31:0] mem [256];

  assign bus.m_txn_done = slave_done | man_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: answers each init after slave_lat cycles unless hung.
  initial begin
    logic [1:0]  s_mode;
    logic [7:0]  s_aa;
    logic [7:0]  s_ab;
    logic [31:0] s_wd;
    bus.m_rdata = '0;
    bus.m_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_init_txn && !slave_hang && reset_n) begin
        s_mode = bus.m_mode;
        s_aa   = bus.m_addra;
        s_ab   = bus.m_addrb;
        s_wd   = bus.m_wdata;
        repeat (slave_lat) @(posedge clk);
        #1;
        if (s_mode == 2'b10) begin
          mem[s_ab]   = s_wd;
          bus.m_rdata = 32'hFFFF_FFFF;
        end else begin
          bus.m_rdata = mem[s_aa];
        end
        bus.m_error    = slave_err;
        slave_done     = 1'b1;
        slave_rise_cyc = cyc;
        @(posedge clk); #1;
        slave_done = 1'b0;
      end
    end
  end

  // Monitor: compares every init and every done pulse against the expected queues.
  initial begin
    logic [49:0] e_iss;
    logic [33:0] e_rsp;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.r0_gnt && bus.r1_gnt) n_dual_gnt++;
        if (bus.m_init_txn && prev_init) n_long_init++;
        if (bus.m_init_txn) begin
          n_init++;
          last_init_cyc = cyc;
          if (chk_turn && last_done_cyc >= 0) check("turnaround", 64'(cyc - last_done_cyc), 64'd2);
          check("init_expected", 64'(exp_iss_q.size() != 0), 64'd1);
          if (exp_iss_q.size() != 0) begin
            e_iss = exp_iss_q.pop_front();
            check("issue_fields", {bus.m_mode, bus.m_addra, bus.m_addrb, bus.m_wdata}, 64'(e_iss));
          end
        end
        if (bus.r0_done || bus.r1_done) begin
          n_done++;
          last_done_cyc = cyc;
          if (bus.r0_done && bus.r1_done) n_dual_done++;
          check("done_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
          if (exp_rsp_q.size() != 0) begin
            e_rsp = exp_rsp_q.pop_front();
            if (bus.r1_done) check("response", {bus.r1_done, bus.r1_err, bus.r1_rdata}, 64'(e_rsp));
            else             check("response", {bus.r1_done, bus.r0_err, bus.r0_rdata}, 64'(e_rsp));
          end
        end
      end
      prev_init = bus.m_init_txn;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic v, input logic wr, input logic [7:0] a,
                           input logic [31:0] d);
    if (id == 0) begin
      bus.r0_req = v; bus.r0_wr = wr; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = v; bus.r1_wr = wr; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  task automatic expect_txn(input logic id, input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic rsp, input logic err, input logic [31:0] rd);
    exp_iss_q.push_back({(wr ? 2'b10 : 2'b01), (wr ? 8'h00 : a), (wr ? a : 8'h00), (wr ? d : 32'h0)});
    if (rsp) exp_rsp_q.push_back({id, err, rd});
  endtask

  task automatic wait_dones(input int n, input int budget);
    int target;
    int k;
    target = n_done + n;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    check("done_within_budget", 64'(n_done), 64'(target));
  endtask

  task automatic wait_inits(input int n, input int budget);
    int target;
    int k;
    target = n_init + n;
    k = 0;
    while (n_init < target && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    check("init_within_budget", 64'(n_init), 64'(target));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {bus.r0_gnt, bus.r0_done, bus.r0_err, bus.r1_gnt, bus.r1_done, bus.r1_err,
                           bus.m_init_txn, bus.m_mode}, 64'd0);
    check({tag, "_rdata"}, {bus.r0_rdata, bus.r1_rdata}, 64'd0);
    check({tag, "_mbus"}, {bus.m_addra, bus.m_addrb, bus.m_wdata}, 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int req_cyc;
    int nd;
    int ni;
    for (int i = 0; i < 256; i++) mem[i] = {24'hC0FFEE, 8'(i)};
    mem[8'h10] = 32'hDEADBEEF;
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(3);
    check_outputs_zero("por");
    reset_n = 1'b1;
    tick(2);

    // 1: r0 read 0x10
    expect_txn(1'b0, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    drive_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
    req_cyc = cyc;
    wait_dones(1, 60);
    check("t1_req_to_init", 64'(last_init_cyc - req_cyc), 64'd1);
    check("t1_edge_to_done", 64'(last_done_cyc - slave_rise_cyc), 64'd1);
    tick(1);
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(2);

    // 2: r1 write 0x22; slave returns junk rdata which must be suppressed
    expect_txn(1'b1, 1'b1, 8'h22, 32'h12345678, 1'b1, 1'b0, 32'h0);
    drive_req(1, 1'b1, 1'b1, 8'h22, 32'h12345678);
    wait_dones(1, 60);
    tick(1);
    drive_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    check("t2_mem_written", 64'(mem[8'h22]), 64'h12345678);
    tick(2);

    // slave error on r0 read 0x11
    slave_err = 1'b1;
    expect_txn(1'b0, 1'b0, 8'h11, 32'h0, 1'b1, 1'b1, 32'hC0FFEE11);
    drive_req(0, 1'b1, 1'b0, 8'h11, 32'h0);
    wait_dones(1, 60);
    tick(1);
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    slave_err = 1'b0;
    tick(2);

    // 3: both held from reset -> r0,r1,r0,r1
    do_reset();
    chk_turn = 1'b1;
    last_done_cyc = -1;
    ni = n_init;
    expect_txn(1'b0, 1'b0, 8'h40, 32'h0, 1'b1, 1'b0, 32'hC0FFEE40);
    expect_txn(1'b1, 1'b1, 8'h50, 32'h0BADF00D, 1'b1, 1'b0, 32'h0);
    expect_txn(1'b0, 1'b0, 8'h40, 32'h0, 1'b1, 1'b0, 32'hC0FFEE40);
    expect_txn(1'b1, 1'b1, 8'h50, 32'h0BADF00D, 1'b1, 1'b0, 32'h0);
    drive_req(0, 1'b1, 1'b0, 8'h40, 32'h0);
    drive_req(1, 1'b1, 1'b1, 8'h50, 32'h0BADF00D);
    wait_dones(4, 200);
    tick(1);
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    chk_turn = 1'b0;
    check("t3_init_count", 64'(n_init - ni), 64'd4);
    check("t3_mem_written", 64'(mem[8'h50]), 64'h0BADF00D);
    tick(2);

    // 4: r0 alone, held for 3 reads
    chk_turn = 1'b1;
    last_done_cyc = -1;
    ni = n_init;
    for (int i = 0; i < 3; i++) expect_txn(1'b0, 1'b0, 8'h30, 32'h0, 1'b1, 1'b0, 32'hC0FFEE30);
    drive_req(0, 1'b1, 1'b0, 8'h30, 32'h0);
    wait_dones(3, 150);
    tick(1);
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    chk_turn = 1'b0;
    check("t4_init_count", 64'(n_init - ni), 64'd3);
    tick(2);

    // 5: hung slave -> timeout error after 16 WAIT cycles, late done ignored
    slave_hang = 1'b1;
    expect_txn(1'b0, 1'b0, 8'h10, 32'h0, 1'b1, 1'b1, 32'h0);
    drive_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
    wait_dones(1, 60);
    check("t5_timeout_latency", 64'(last_done_cyc - last_init_cyc), 64'd17);
    tick(1);
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(2);
    nd = n_done;
    man_done = 1'b1;
    tick(3);
    man_done = 1'b0;
    tick(4);
    check("t5_late_done_ignored", 64'(n_done), 64'(nd));
    check("t5_state_idle", 64'(dbg_state), 64'd0);

    // txn_done already high on entry must not complete the write
    man_done = 1'b1;
    tick(2);
    expect_txn(1'b1, 1'b1, 8'h60, 32'h5555AAAA, 1'b1, 1'b0, 32'h0);
    drive_req(1, 1'b1, 1'b1, 8'h60, 32'h5555AAAA);
    wait_inits(1, 20);
    nd = n_done;
    tick(6);
    check("level_no_complete", 64'(n_done), 64'(nd));
    check("level_state_wait", 64'(dbg_state), 64'd2);
    man_done = 1'b0;
    tick(1);
    man_done = 1'b1;
    wait_dones(1, 20);
    tick(1);
    drive_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    man_done = 1'b0;
    tick(2);

    // 6: reset during WAIT aborts without a done pulse
    expect_txn(1'b0, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
    wait_inits(1, 20);
    tick(3);
    nd = n_done;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_abort");
    tick(2);
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    reset_n = 1'b1;
    tick(3);
    check("t6_no_done", 64'(n_done), 64'(nd));
    slave_hang = 1'b0;
    expect_txn(1'b0, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    drive_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
    wait_dones(1, 60);
    tick(1);
    drive_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(3);

    check("dual_grant_cycles", 64'(n_dual_gnt), 64'd0);
    check("dual_done_cycles", 64'(n_dual_done), 64'd0);
    check("long_init_pulses", 64'(n_long_init), 64'd0);
    check("issue_queue_empty", 64'(exp_iss_q.size()), 64'd0);
    check("resp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
